neuron_par: RTL and testbench

NEURON_PAR -- requirements
Module: neuron_par

---
 rtl/neuron_par.sv | 210 +++++++++++++++++++++
 tb/tb_neuron_par.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_par.sv
// Single neuron, LANES-wide MAC pipeline with saturating accumulate.
// Ports: clk/rst_n, in_* beat stream, weight/bias load, act_mode, out_* result.
module neuron_par #(
  parameter int LAYER_NO   = 0,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 8,
  parameter int LANES      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        weight_valid,
  input  logic [31:0]                 weight_value,
  input  logic                        bias_valid,
  input  logic [31:0]                 bias_value,
  input  logic [31:0]                 config_layer_num,
  input  logic [31:0]                 config_neuron_num,
  input  logic [1:0]                  act_mode,
  output logic [DATA_WIDTH-1:0]       out,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int DW    = DATA_WIDTH;
  localparam int W2    = 2 * DW;
  localparam int TW    = W2 + $clog2(LANES);
  localparam int BEATS = NUM_WEIGHT / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic signed [W2-1:0] MAXW = {1'b0, {(W2-1){1'b1}}};
  localparam logic signed [W2-1:0] MINW = {1'b1, {(W2-1){1'b0}}};
  localparam logic signed [DW-1:0] MAXD = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIND = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

  function automatic logic signed [W2-1:0] sat_tree(
    input logic signed [TW-1:0] v
  );
    if (&v[TW-1:W2-1] || ~|v[TW-1:W2-1]) return v[W2-1:0];
    return v[TW-1] ? MINW : MAXW;
  endfunction

  function automatic logic signed [W2-1:0] sat_add(
    input logic signed [W2-1:0] a,
    input logic signed [W2-1:0] b
  );
    logic signed [W2:0] s;
    s = {a[W2-1], a} + {b[W2-1], b};
    if (s[W2] != s[W2-1]) return s[W2] ? MINW : MAXW;
    return s[W2-1:0];
  endfunction

  function automatic logic signed [DW-1:0] sat_out(
    input logic signed [W2-1:0] v
  );
    if (&v[W2-1:DW-1] || ~|v[W2-1:DW-1]) return v[DW-1:0];
    return v[W2-1] ? MIND : MAXD;
  endfunction

  state_t                  state;
  logic [BW-1:0]           beat_cnt;
  logic [BW-1:0]           wr_beat;
  logic [LW-1:0]           wr_lane;
  logic signed [W2-1:0]    bias_q;
  logic [LANES-1:0][DW-1:0] mem [BEATS];

  logic                    cfg_hit;
  logic                    accept;

  logic [LANES*DW-1:0]      e1_x;
  logic [LANES-1:0][DW-1:0] e1_w;
  logic                     e1_valid, e1_last;
  logic signed [W2-1:0]     prod [LANES];
  logic                     e2_valid, e2_last;
  logic signed [TW-1:0]     tree_c;
  logic signed [W2-1:0]     e3_sum;
  logic                     e3_valid, e3_last;
  logic signed [W2-1:0]     acc;
  logic                     fin;
  logic signed [W2-1:0]     biased_c;
  logic signed [W2-1:0]     shifted_c;
  logic signed [DW-1:0]     pre;
  logic                     pre_valid;
  logic signed [DW-1:0]     act_c;

  assign cfg_hit  = (config_layer_num == 32'(LAYER_NO)) &&
                    (config_neuron_num == 32'(NEURON_NO));
  assign in_ready = (state == ACC);
  assign accept   = in_valid && in_ready;

  // Weight storage is deliberately unreset so it survives rst_n.
  always_ff @(posedge clk) begin
    if (cfg_hit && weight_valid)
      mem[wr_beat][wr_lane] <= weight_value[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_beat <= '0;
      wr_lane <= '0;
      bias_q  <= '0;
    end else begin
      if (cfg_hit && weight_valid) begin
        if (wr_lane == LW'(LANES-1)) begin
          wr_lane <= '0;
          wr_beat <= (wr_beat == BW'(BEATS-1)) ? '0 : wr_beat + BW'(1);
        end else begin
          wr_lane <= wr_lane + LW'(1);
        end
      end
      if (cfg_hit && bias_valid)
        bias_q <= {{DW{bias_value[DW-1]}}, bias_value[DW-1:0]} << FRAC;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      e1_x <= in_data;
      e1_w <= mem[beat_cnt];
    end
    if (e1_valid) begin
      for (int l = 0; l < LANES; l++)
        prod[l] <= W2'($signed(e1_x[l*DW +: DW])) *
                   W2'($signed(e1_w[l]));
    end
    if (e2_valid)
      e3_sum <= sat_tree(tree_c);
  end

  always_comb begin
    tree_c = '0;
    for (int l = 0; l < LANES; l++)
      tree_c = tree_c + TW'(prod[l]);
  end

  assign biased_c  = sat_add(acc, bias_q);
  assign shifted_c = biased_c >>> FRAC;

  always_comb begin
    act_c = pre;
    unique case (act_mode)
      2'd1:    act_c = pre[DW-1] ? '0 : pre;
      2'd2:    act_c = pre[DW-1] ? (pre >>> 3) : pre;
      default: act_c = pre;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      beat_cnt  <= '0;
      e1_valid  <= 1'b0;
      e1_last   <= 1'b0;
      e2_valid  <= 1'b0;
      e2_last   <= 1'b0;
      e3_valid  <= 1'b0;
      e3_last   <= 1'b0;
      acc       <= '0;
      fin       <= 1'b0;
      pre       <= '0;
      pre_valid <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      e1_valid  <= accept;
      e1_last   <= accept && (beat_cnt == BW'(BEATS-1));
      e2_valid  <= e1_valid;
      e2_last   <= e1_valid && e1_last;
      e3_valid  <= e2_valid;
      e3_last   <= e2_valid && e2_last;
      fin       <= e3_valid && e3_last;
      pre_valid <= fin;
      if (e3_valid)
        acc <= sat_add(acc, e3_sum);
      if (fin)
        pre <= sat_out(shifted_c);
      unique case (state)
        ACC: begin
          if (accept) begin
            if (beat_cnt == BW'(BEATS-1)) state <= DRAIN;
            else beat_cnt <= beat_cnt + BW'(1);
          end
        end
        DRAIN: begin
          if (pre_valid) begin
            out       <= act_c;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_par.sv
// Directed bench for neuron_par with expected-result scoreboard.
module tb_neuron_par;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        weight_valid;
  logic [31:0] weight_value;
  logic        bias_valid;
  logic [31:0] bias_value;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic [1:0]  act_mode;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  neuron_par dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num),
    .act_mode(act_mode),
    .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [15:0] v, input logic [31:0] nrn);
    config_neuron_num = nrn;
    for (int k = 0; k < 8; k++) begin
      weight_valid = 1'b1;
      weight_value = {16'h0, v};
      tick();
    end
    weight_valid = 1'b0;
    config_neuron_num = 32'd0;
  endtask

  task automatic load_b(input logic [15:0] v, input logic [31:0] nrn);
    config_neuron_num = nrn;
    bias_valid = 1'b1;
    bias_value = {16'h0, v};
    tick();
    bias_valid = 1'b0;
    config_neuron_num = 32'd0;
  endtask

  task automatic run(input string tag, input logic [15:0] b0,
                     input logic [15:0] b1, input int bubbles,
                     input logic [1:0] mode, input logic [15:0] exp,
                     input int hold);
    int n;
    logic [15:0] e;
    logic [15:0] held;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    act_mode = mode;
    in_data  = {4{b0}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (bubbles) tick();
    in_data  = {4{b1}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(exp);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd5);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk({tag, "_out"}, 32'(out), 32'(e));
    held = out;
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      in_data  = {4{16'h1234}};
      tick();
      chk({tag, "_hold_out"}, 32'(out), 32'(held));
      chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy2"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    weight_valid = 1'b0;
    weight_value = '0;
    bias_valid = 1'b0;
    bias_value = '0;
    config_layer_num = 32'd0;
    config_neuron_num = 32'd0;
    act_mode = 2'd0;
    out_ready = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", 32'(in_ready), 32'd1);

    load_w(16'h0100, 32'd0);
    load_b(16'h0080, 32'd0);
    run("basic", 16'h0100, 16'h0100, 0, 2'd0, 16'h0880, 0);

    load_w(16'h7FFF, 32'd0);
    load_b(16'h0000, 32'd0);
    run("sat", 16'h7FFF, 16'h7FFF, 0, 2'd0, 16'h7FFF, 0);

    load_w(16'h0100, 32'd0);
    run("lin", 16'hFF00, 16'hFF00, 0, 2'd0, 16'hF800, 0);
    run("relu", 16'hFF00, 16'hFF00, 0, 2'd1, 16'h0000, 0);
    run("leaky", 16'hFF00, 16'hFF00, 1, 2'd2, 16'hFF00, 0);

    load_b(16'h0080, 32'd0);
    run("hold", 16'h0100, 16'h0100, 0, 2'd0, 16'h0880, 10);
    run("after", 16'h0100, 16'h0100, 0, 2'd0, 16'h0880, 0);

    load_w(16'h0200, 32'd1);
    load_b(16'h0400, 32'd1);
    run("nomatch", 16'h0100, 16'h0100, 0, 2'd0, 16'h0880, 0);

    in_data  = {4{16'h0100}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_rst_vld", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("abort_vld", 32'(out_valid), 32'd0);
    end
    chk("abort_rdy", 32'(in_ready), 32'd1);
    load_b(16'h0080, 32'd0);
    run("bubble", 16'h0100, 16'h0100, 3, 2'd0, 16'h0880, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
